// File: rtl/serial_line_tx.sv
// serial_line_tx: handshake-fed parallel-to-serial transmitter with a one-word holding register and optional inter-word gap.
// Define SERIAL_LINE_TX_LSB_FIRST_EN to shift words out LSB first (default MSB first).
module serial_line_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int GAP_CYCLES = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic                  serial_line,
   output logic                  word_done,
   output logic                  busy
);
   localparam int CW = $clog2(DATA_WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
   state_t state, state_nx;
   logic [DATA_WIDTH-1:0] hold, shifter, shifted;
   logic hold_full, take, load, last_bit, gap_end, cur_bit, line_nx;
   logic [CW-1:0] bit_cnt;
   logic [3:0] gap_cnt;
   assign data_ready = !hold_full && !reset;
   assign busy       = state != IDLE || hold_full;
   assign take       = data_valid && data_ready;
   assign last_bit   = state == SHIFT && bit_cnt == CW'(DATA_WIDTH - 1);
   assign gap_end    = state == GAP && gap_cnt == 4'(GAP_CYCLES - 1);
`ifdef SERIAL_LINE_TX_LSB_FIRST_EN
   assign cur_bit = shifter[0];
   assign shifted = {1'b0, shifter[DATA_WIDTH-1:1]};
`else
   assign cur_bit = shifter[DATA_WIDTH-1];
   assign shifted = {shifter[DATA_WIDTH-2:0], 1'b0};
`endif
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (hold_full) state_nx = SHIFT;
         SHIFT:   if (last_bit) state_nx = (GAP_CYCLES > 0) ? GAP : (hold_full ? SHIFT : IDLE);
         GAP:     if (gap_end) state_nx = hold_full ? SHIFT : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // a load empties hold, which is only refilled when data_ready is high, so the two never collide
   always_comb begin
      load    = hold_full && (state == IDLE || (last_bit && GAP_CYCLES == 0) || gap_end);
      line_nx = state == SHIFT && cur_bit;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         hold        <= '0;
         hold_full   <= 1'b0;
         shifter     <= '0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         serial_line <= 1'b0;
         word_done   <= 1'b0;
      end else begin
         if (take) begin
            hold      <= data_in;
            hold_full <= 1'b1;
         end else if (load) hold_full <= 1'b0;
         shifter     <= load ? hold : (state == SHIFT ? shifted : shifter);
         bit_cnt     <= (load || last_bit) ? '0 : (state == SHIFT ? bit_cnt + 1'b1 : bit_cnt);
         gap_cnt     <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
         serial_line <= line_nx;
         word_done   <= last_bit;
      end
endmodule

// File: tb/tb_serial_line_tx.sv
// tb_serial_line_tx: directed table-driven bench for serial_line_tx (GAP 0 and GAP 3 instances).
module tb_serial_line_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [7:0] d0 = 8'h00, d1 = 8'h00;
   logic v0 = 1'b0, v1 = 1'b0;
   logic r0, r1, l0, l1, w0, w1, b0, b1;
   int n_cmp = 0, n_bad = 0;
   serial_line_tx #(.DATA_WIDTH(8), .GAP_CYCLES(0)) dut (
      .clock(clk), .reset(rst), .data_in(d0), .data_valid(v0), .data_ready(r0),
      .serial_line(l0), .word_done(w0), .busy(b0));
   serial_line_tx #(.DATA_WIDTH(8), .GAP_CYCLES(3)) dut_g (
      .clock(clk), .reset(rst), .data_in(d1), .data_valid(v1), .data_ready(r1),
      .serial_line(l1), .word_done(w1), .busy(b1));
   typedef struct {
      logic [7:0] data;
      logic [7:0] msb_s;
      logic [7:0] lsb_s;
   } vec_t;
   vec_t tbl[6];
   logic [7:0] s11;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   // stream is written in time order, first transmitted bit in bit 7
   task automatic expect_word(input string tag, input logic [7:0] s, input bit sel);
      for (int i = 0; i < 8; i++) begin
         step;
         chk($sformatf("%s_bit%0d", tag, i), sel ? l1 : l0, s[7-i]);
         chk($sformatf("%s_done%0d", tag, i), sel ? w1 : w0, i == 7);
      end
   endtask
   task automatic expect_zero(input string tag, input int n, input bit sel);
      for (int i = 0; i < n; i++) begin
         step;
         chk($sformatf("%s_zero%0d", tag, i), sel ? l1 : l0, 0);
         chk($sformatf("%s_zdone%0d", tag, i), sel ? w1 : w0, 0);
      end
   endtask
   task automatic send0(input logic [7:0] d);
      int k;
      k = 0;
      v0 = 1'b1;
      d0 = d;
      while (!r0 && k < 50) begin
         step;
         k++;
      end
      chk("ready_wait", r0, 1);
      step;
      v0 = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
      tbl[1] = '{8'h3C, 8'h3C, 8'h3C};
      tbl[2] = '{8'hFF, 8'hFF, 8'hFF};
      tbl[3] = '{8'h01, 8'h01, 8'h80};
      tbl[4] = '{8'h80, 8'h80, 8'h01};
      tbl[5] = '{8'h6B, 8'h6B, 8'hD6};
`ifdef SERIAL_LINE_TX_LSB_FIRST_EN
      s11 = 8'h88;
`else
      s11 = 8'h11;
`endif
      repeat (3) step;
      chk("rst_line", l0, 0);
      chk("rst_done", w0, 0);
      chk("rst_busy", b0, 0);
      chk("rst_ready", r0, 0);
      chk("rst_ready_g", r1, 0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", r0, 1);
      chk("ready_after_rst_g", r1, 1);
      for (int t = 0; t < 6; t++) begin
         send0(tbl[t].data);
         step;
         chk($sformatf("v%0d_latency", t), l0, 0);
         chk($sformatf("v%0d_busy", t), b0, 1);
`ifdef SERIAL_LINE_TX_LSB_FIRST_EN
         expect_word($sformatf("v%0d", t), tbl[t].lsb_s, 0);
`else
         expect_word($sformatf("v%0d", t), tbl[t].msb_s, 0);
`endif
         expect_zero($sformatf("v%0d", t), 2, 0);
         chk($sformatf("v%0d_idle", t), b0, 0);
      end
      // back-to-back A5 then 3C with valid held: no idle bit between words
      v0 = 1'b1;
      d0 = 8'hA5;
      step;
      d0 = 8'h3C;
      step;
      chk("b2b_latency", l0, 0);
      expect_word("b2b_a5", 8'hA5, 0);
      v0 = 1'b0;
      expect_word("b2b_3c", 8'h3C, 0);
      expect_zero("b2b", 2, 0);
      chk("b2b_idle", b0, 0);
      // data changes while not ready must be ignored
      v0 = 1'b1;
      d0 = 8'hC3;
      step;
      d0 = 8'h11;
      step;
      chk("chg_latency", l0, 0);
      fork
         expect_word("chg_c3", 8'hC3, 0);
         begin
            step;
            d0 = 8'h22;
            chk("chg_not_ready", r0, 0);
            step;
            d0 = 8'h33;
            step;
            v0 = 1'b0;
         end
      join
      expect_word("chg_11", s11, 0);
      expect_zero("chg", 4, 0);
      chk("chg_idle", b0, 0);
      // gap instance: FF twice -> 8 ones, 3 zeros, 8 ones
      v1 = 1'b1;
      d1 = 8'hFF;
      step;
      step;
      chk("gap_latency", l1, 0);
      fork
         expect_word("gap_w1", 8'hFF, 1);
         begin
            step;
            v1 = 1'b0;
         end
      join
      expect_zero("gap_mid", 3, 1);
      expect_word("gap_w2", 8'hFF, 1);
      expect_zero("gap_end", 3, 1);
      chk("gap_idle", b1, 0);
      // reset during the 4th bit of FF with a second word held
      v0 = 1'b1;
      d0 = 8'hFF;
      step;
      step;
      for (int i = 0; i < 4; i++) begin
         step;
         chk($sformatf("mid_bit%0d", i), l0, 1);
      end
      v0 = 1'b0;
      chk("mid_hold_full", r0, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_line", l0, 0);
      chk("mid_rst_busy", b0, 0);
      chk("mid_rst_ready", r0, 0);
      chk("mid_rst_done", w0, 0);
      step;
      step;
      rst = 1'b0;
      #1;
      chk("mid_rel_ready", r0, 1);
      expect_zero("mid_rel", 12, 0);
      chk("mid_rel_busy", b0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/serial_line_tx.md
SERIAL_LINE_TX -- requirements
Module: serial_line_tx

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 8, word width in bits (legal 2..32).
REQ-002 The block SHALL provide parameter GAP_CYCLES, default 0, forced-low cycles after every word (legal 0..15).
REQ-003 Port clock  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port data_in  in  DATA_WIDTH  parallel word to serialize; sampled only on a handshake edge.
REQ-006 Port data_valid  in  1  upstream offers data_in.
REQ-007 Port data_ready  out  1  block can accept a word; handshake = data_valid && data_ready at a rising edge.
REQ-008 Port serial_line  out  1  registered serial bit stream, one bit per clock, feeding the downstream serial_line FSM.
REQ-009 Port word_done  out  1  high exactly in the cycle serial_line carries the last bit of a word.
REQ-010 Port busy  out  1  high when state != IDLE or holding register full.

Function
REQ-011 Storage SHALL be a one-word holding register (hold, hold_full), a DATA_WIDTH shift register, a bit counter and a gap counter.
REQ-012 data_ready SHALL equal !hold_full && !reset; the handshake edge SHALL write data_in into hold and set hold_full.
REQ-013 FSM states SHALL be IDLE, SHIFT, GAP; serial_line SHALL be 0 in IDLE and GAP.
REQ-014 IDLE: at an edge with hold_full=1, load shifter from hold, clear hold_full, bit counter=0, go SHIFT.
REQ-015 Latency: first bit SHALL appear on serial_line two edges after the handshake edge when starting from IDLE.
REQ-016 SHIFT: one bit per cycle; DATA_WIDTH bits per word; bit counter wraps to 0 on the last-bit edge.
REQ-017 Last-bit edge, GAP_CYCLES=0: if hold_full, reload shifter and stay SHIFT (no idle bit between words); else go IDLE.
REQ-018 Last-bit edge, GAP_CYCLES>0: go GAP; after exactly GAP_CYCLES low cycles, load if hold_full (go SHIFT) else go IDLE.
REQ-019 Hold-to-shifter transfer and a new handshake SHALL never coincide (data_ready low while hold_full), so no word is dropped or duplicated.
REQ-020 data_in/data_valid changes while data_ready=0 SHALL have no effect on state or output.
REQ-021 word_done SHALL be a one-cycle pulse per word; back-to-back words give one pulse per DATA_WIDTH cycles.

Reset
REQ-022 While reset=1: state=IDLE, hold_full=0, counters=0, serial_line=0, word_done=0, busy=0, data_ready=0.
REQ-023 Reset asserted mid-word SHALL immediately force serial_line=0 and discard both the in-flight and held word.
REQ-024 data_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-025 With SERIAL_LINE_TX_LSB_FIRST_EN defined, words SHALL be transmitted LSB first.
REQ-026 Without SERIAL_LINE_TX_LSB_FIRST_EN, words SHALL be transmitted MSB first. Latency, gap and handshake timing are identical in both builds.

Verification
REQ-027 Reset during the 4th bit of 8'hFF -> serial_line 0 immediately, busy 0, data_ready 0; after release data_ready 1, line stays 0.
REQ-028 DATA_WIDTH=8, GAP=0, single 8'hA5 handshake at edge N -> serial_line 1,0,1,0,0,1,0,1 after edges N+2..N+9, word_done only in the final bit cycle, then 0.
REQ-029 8'hA5 then 8'h3C offered continuously -> 16 contiguous bits 1010010100111100, no zero gap, two word_done pulses 8 cycles apart.
REQ-030 GAP_CYCLES=3, 8'hFF twice back-to-back -> 8 ones, exactly 3 zeros, 8 ones.
REQ-031 SERIAL_LINE_TX_LSB_FIRST_EN defined, 8'h01 -> 1 followed by seven 0s.
REQ-032 data_valid held with data_in changing 8'h11 -> 8'h22 while data_ready=0 -> only the value present at the handshake edge is transmitted, exactly once.
